// File: rtl/u_wbu_super_scalar_pkg.sv
// Shared core defines used by the LSU, IDU and writeback unit.
package u_wbu_super_scalar_pkg;

  localparam int unsigned SUPER_SCALAR_NUM = 2;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned PC_WIDTH         = 32;
  localparam int unsigned RF_DEPTH_BIT     = 5;
  localparam int unsigned RF_READS_PER_LANE = 2;
  localparam int unsigned RETIRE_CNT_WIDTH = 64;

  // A retiring lane updates the register file only when valid, writing, and not targeting x0.
  function automatic logic wr_effective(input logic vld, input logic wen, input logic rd_nonzero);
    return vld & wen & rd_nonzero;
  endfunction

endpackage

// File: rtl/u_wbu_super_scalar_rf.sv
// Register array with NUM_WR write ports and NUM_RD combinational read ports.
// Entry 0 is never written and always reads as zero. When several ports
// write the same entry, the highest-numbered (youngest) port wins.
module u_rf_2w4r #(
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned NUM_RD     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_WR-1:0]                     wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wr_data_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]     rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_data_c_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Array update: reset clears every entry; later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] != '0)) begin
          mem_q[wr_addr_i[w]] <= wr_data_i[w];
        end
      end
    end
  end

  // Asynchronous reads with x0 hardwired to zero.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_c_o[r] = (rd_addr_i[r] == '0) ? '0 : mem_q[rd_addr_i[r]];
    end
  end

endmodule

// File: rtl/u_wbu_super_scalar.sv
// Superscalar writeback unit: register-file writes, read bypass, retire PC tracking.
// Optional feature: define WBU_RETIRE_CNT_EN to add the 64-bit wbu_retire_cnt output.
module u_wbu_super_scalar #(
  parameter int unsigned SUPER_SCALAR_NUM = u_wbu_super_scalar_pkg::SUPER_SCALAR_NUM,
  parameter int unsigned DATA_WIDTH       = u_wbu_super_scalar_pkg::DATA_WIDTH,
  parameter int unsigned PC_WIDTH         = u_wbu_super_scalar_pkg::PC_WIDTH,
  parameter int unsigned RF_DEPTH_BIT     = u_wbu_super_scalar_pkg::RF_DEPTH_BIT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [SUPER_SCALAR_NUM-1:0]                 lsu_rf_pipe_vld,
  input  logic [SUPER_SCALAR_NUM-1:0][PC_WIDTH-1:0]   lsu_rf_pc,
  input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0] lsu_rf_rd,
  input  logic [SUPER_SCALAR_NUM-1:0]                 lsu_rf_wen,
  input  logic [SUPER_SCALAR_NUM-1:0][DATA_WIDTH-1:0] lsu_rf_wr_data,
  input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0] idu_rf_rs1,
  input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0] idu_rf_rs2,
  output logic [SUPER_SCALAR_NUM-1:0][DATA_WIDTH-1:0] rf_idu_rs1_data,
  output logic [SUPER_SCALAR_NUM-1:0][DATA_WIDTH-1:0] rf_idu_rs2_data,
  output logic [PC_WIDTH-1:0]                         wbu_last_pc,
`ifdef WBU_RETIRE_CNT_EN
  output logic [u_wbu_super_scalar_pkg::RETIRE_CNT_WIDTH-1:0] wbu_retire_cnt,
`endif
  output logic                                        wbu_retire_vld
);

  import u_wbu_super_scalar_pkg::*;

  localparam int unsigned NUM_RD = RF_READS_PER_LANE * SUPER_SCALAR_NUM;

  logic [SUPER_SCALAR_NUM-1:0]                   wr_eff;
  logic [NUM_RD-1:0][RF_DEPTH_BIT-1:0]           rf_rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]             rf_rd_data;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]             fwd_data;
  logic [PC_WIDTH-1:0]                           last_pc_q, last_pc_d;
  logic                                          retire_vld_q, retire_vld_d;

  // Per-lane effective write qualifier and read-port address mapping.
  for (genvar l = 0; l < SUPER_SCALAR_NUM; l++) begin : g_lane
    assign wr_eff[l] = wr_effective(lsu_rf_pipe_vld[l], lsu_rf_wen[l], lsu_rf_rd[l] != '0);
    assign rf_rd_addr[RF_READS_PER_LANE*l]     = idu_rf_rs1[l];
    assign rf_rd_addr[RF_READS_PER_LANE*l + 1] = idu_rf_rs2[l];
    assign rf_idu_rs1_data[l] = fwd_data[RF_READS_PER_LANE*l];
    assign rf_idu_rs2_data[l] = fwd_data[RF_READS_PER_LANE*l + 1];
  end

  u_rf_2w4r #(
    .NUM_WR     (SUPER_SCALAR_NUM),
    .NUM_RD     (NUM_RD),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RF_DEPTH_BIT)
  ) u_rf (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_eff),
    .wr_addr_i   (lsu_rf_rd),
    .wr_data_i   (lsu_rf_wr_data),
    .rd_addr_i   (rf_rd_addr),
    .rd_data_c_o (rf_rd_data)
  );

  // Same-cycle bypass: younger lanes are scanned last so they take priority; reset blanks reads.
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      fwd_data[r] = rf_rd_data[r];
      for (int l = 0; l < SUPER_SCALAR_NUM; l++) begin
        if (wr_eff[l] && (lsu_rf_rd[l] == rf_rd_addr[r])) begin
          fwd_data[r] = lsu_rf_wr_data[l];
        end
      end
      if (rst) begin
        fwd_data[r] = '0;
      end
    end
  end

  // Next retire state: PC of the youngest valid lane, otherwise hold.
  always_comb begin
    last_pc_d    = last_pc_q;
    retire_vld_d = |lsu_rf_pipe_vld;
    for (int l = 0; l < SUPER_SCALAR_NUM; l++) begin
      if (lsu_rf_pipe_vld[l]) begin
        last_pc_d = lsu_rf_pc[l];
      end
    end
  end

  // Retire status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q    <= '0;
      retire_vld_q <= 1'b0;
    end else begin
      last_pc_q    <= last_pc_d;
      retire_vld_q <= retire_vld_d;
    end
  end

  assign wbu_last_pc    = last_pc_q;
  assign wbu_retire_vld = retire_vld_q;

`ifdef WBU_RETIRE_CNT_EN
  logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  // Retired-instruction count: add the number of valid lanes, wrapping naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    for (int l = 0; l < SUPER_SCALAR_NUM; l++) begin
      retire_cnt_d = retire_cnt_d + RETIRE_CNT_WIDTH'(lsu_rf_pipe_vld[l]);
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wbu_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_u_wbu_super_scalar.sv
// Self-checking bench for u_wbu_super_scalar: directed vector table, counter
// sequence (when WBU_RETIRE_CNT_EN is defined) and randomized traffic against
// an architectural register-file model.
module tb_u_wbu_super_scalar;

  logic             clk;
  logic             rst;
  logic [1:0]       vld;
  logic [1:0][31:0] pc;
  logic [1:0][4:0]  rd;
  logic [1:0]       wen;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0]  rs1;
  logic [1:0][4:0]  rs2;
  logic [1:0][31:0] rs1_data;
  logic [1:0][31:0] rs2_data;
  logic [31:0]      last_pc;
  logic             retire_vld;
`ifdef WBU_RETIRE_CNT_EN
  logic [63:0]      retire_cnt;
`endif

  int total = 0;
  int bad   = 0;

  u_wbu_super_scalar dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_rf_pipe_vld (vld),
    .lsu_rf_pc       (pc),
    .lsu_rf_rd       (rd),
    .lsu_rf_wen      (wen),
    .lsu_rf_wr_data  (wdata),
    .idu_rf_rs1      (rs1),
    .idu_rf_rs2      (rs2),
    .rf_idu_rs1_data (rs1_data),
    .rf_idu_rs2_data (rs2_data),
    .wbu_last_pc     (last_pc),
`ifdef WBU_RETIRE_CNT_EN
    .wbu_retire_cnt  (retire_cnt),
`endif
    .wbu_retire_vld  (retire_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic        m_ret;
  logic [63:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value an instruction in decode sees for register a this cycle.
  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    if (rst || a == 5'd0) return 32'h0;
    v = m_rf[a];
    if (vld[0] && wen[0] && rd[0] == a) v = wdata[0];
    if (vld[1] && wen[1] && rd[1] == a) v = wdata[1];
    return v;
  endfunction

  // Architectural effect of the current inputs at a clock edge.
  task automatic m_commit();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_pc  = 32'h0;
      m_ret = 1'b0;
      m_cnt = 64'h0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (vld[l] && wen[l] && rd[l] != 5'd0) m_rf[rd[l]] = wdata[l];
      end
      if (vld[1]) m_pc = pc[1];
      else if (vld[0]) m_pc = pc[0];
      m_ret = vld[0] | vld[1];
      m_cnt = m_cnt + 64'(vld[0]) + 64'(vld[1]);
    end
  endtask

  task automatic compare_model();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rnd_rs1_l%0d x%0d", l, rs1[l]), 64'(rs1_data[l]), 64'(m_read(rs1[l])));
      chk($sformatf("rnd_rs2_l%0d x%0d", l, rs2[l]), 64'(rs2_data[l]), 64'(m_read(rs2[l])));
    end
    chk("rnd_last_pc", 64'(last_pc), 64'(m_pc));
    chk("rnd_retire_vld", 64'(retire_vld), 64'(m_ret));
`ifdef WBU_RETIRE_CNT_EN
    chk("rnd_retire_cnt", retire_cnt, m_cnt);
`endif
  endtask

  // Clock edge, model update, then step to the drive point after the edge.
  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  wen;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [31:0] pc0;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic [31:0] pc1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] er0;
    logic [31:0] er1;
    logic [31:0] elpc;
    logic        eret;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] w,
                              input logic [4:0] rd0, input logic [31:0] d0, input logic [31:0] pc0,
                              input logic [4:0] rd1, input logic [31:0] d1, input logic [31:0] pc1,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] er0, input logic [31:0] er1,
                              input logic [31:0] elpc, input logic eret);
    vec_t t;
    t.rst = r; t.vld = v; t.wen = w;
    t.rd0 = rd0; t.d0 = d0; t.pc0 = pc0;
    t.rd1 = rd1; t.d1 = d1; t.pc1 = pc1;
    t.ra0 = ra0; t.ra1 = ra1; t.er0 = er0; t.er1 = er1;
    t.elpc = elpc; t.eret = eret;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    rst = t.rst; vld = t.vld; wen = t.wen;
    rd[0] = t.rd0; wdata[0] = t.d0; pc[0] = t.pc0;
    rd[1] = t.rd1; wdata[1] = t.d1; pc[1] = t.pc1;
    rs1[0] = t.ra0; rs2[0] = t.ra0;
    rs1[1] = t.ra1; rs2[1] = t.ra1;
  endtask

  task automatic idle();
    rst = 1'b0; vld = '0; wen = '0; rd = '0; wdata = '0; pc = '0;
  endtask

  vec_t vecs[13];

  initial begin
    // Directed vectors: expected reads are same-cycle, retire outputs reflect the previous cycle.
    vecs[0]  = mk(0, 2'b01, 2'b01, 5, 32'hDEADBEEF, 32'h10, 0, 0, 0,            5, 5,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,  0);
    vecs[1]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            5, 0,   32'hDEADBEEF, 32'h0,        32'h10, 1);
    vecs[2]  = mk(0, 2'b11, 2'b11, 7, 32'h11, 32'h20, 7, 32'h22, 32'h24,        7, 7,   32'h22,       32'h22,       32'h10, 0);
    vecs[3]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            7, 5,   32'h22,       32'hDEADBEEF, 32'h24, 1);
    vecs[4]  = mk(0, 2'b01, 2'b01, 0, 32'hFFFFFFFF, 32'h30, 0, 0, 0,            0, 0,   32'h0,        32'h0,        32'h24, 0);
    vecs[5]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            0, 7,   32'h0,        32'h22,       32'h30, 1);
    vecs[6]  = mk(0, 2'b00, 2'b01, 3, 32'hABCD, 32'h40, 0, 0, 0,                3, 3,   32'h0,        32'h0,        32'h30, 0);
    vecs[7]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            3, 3,   32'h0,        32'h0,        32'h30, 0);
    vecs[8]  = mk(0, 2'b01, 2'b11, 9, 32'h55, 32'h50, 9, 32'h99, 32'h54,        9, 9,   32'h55,       32'h55,       32'h30, 0);
    vecs[9]  = mk(1, 2'b01, 2'b01, 9, 32'h66, 32'h60, 0, 0, 0,                  9, 9,   32'h0,        32'h0,        32'h50, 1);
    vecs[10] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            9, 5,   32'h0,        32'h0,        32'h0,  0);
    vecs[11] = mk(0, 2'b10, 2'b10, 0, 0, 0, 12, 32'h1234, 32'h70,               12, 12, 32'h1234,     32'h1234,     32'h0,  0);
    vecs[12] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                            12, 0,  32'h1234,     32'h0,        32'h70, 1);

    idle();
    rs1 = '0; rs2 = '0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hX;
    m_pc = 32'hX; m_ret = 1'bX; m_cnt = 64'hX;
    tick();
    tick();

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #4;
      chk($sformatf("vec%0d rs1_l0", i), 64'(rs1_data[0]), 64'(vecs[i].er0));
      chk($sformatf("vec%0d rs2_l0", i), 64'(rs2_data[0]), 64'(vecs[i].er0));
      chk($sformatf("vec%0d rs1_l1", i), 64'(rs1_data[1]), 64'(vecs[i].er1));
      chk($sformatf("vec%0d rs2_l1", i), 64'(rs2_data[1]), 64'(vecs[i].er1));
      chk($sformatf("vec%0d last_pc", i), 64'(last_pc), 64'(vecs[i].elpc));
      chk($sformatf("vec%0d retire_vld", i), 64'(retire_vld), 64'(vecs[i].eret));
      tick();
    end

`ifdef WBU_RETIRE_CNT_EN
    // Counter sequence from a clean reset: {11, 01, 00} retires three instructions.
    idle(); rst = 1'b1; #4; tick();
    idle(); vld = 2'b11; pc[0] = 32'h100; pc[1] = 32'h104; #4; tick();
    idle(); vld = 2'b01; pc[0] = 32'h108; #4; tick();
    idle(); #4; tick();
    idle(); #4;
    chk("cnt_seq retire_cnt", retire_cnt, 64'd3);
    chk("cnt_seq last_pc", 64'(last_pc), 64'h108);
    chk("cnt_seq retire_vld", 64'(retire_vld), 64'h0);
    tick();
`endif

    // Randomized traffic over a narrow register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      vld = 2'($urandom);
      wen = 2'($urandom);
      for (int l = 0; l < 2; l++) begin
        rd[l]    = 5'($urandom_range(0, 7));
        wdata[l] = $urandom;
        pc[l]    = $urandom;
        rs1[l]   = 5'($urandom_range(0, 7));
        rs2[l]   = 5'($urandom_range(0, 7));
      end
      #4;
      compare_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u_wbu_super_scalar.md
U_WBU_SUPER_SCALAR -- requirements
Module: u_wbu_super_scalar

Interface
REQ-001 SHALL take parameter SUPER_SCALAR_NUM, default 2: lane count; lane 1 is always younger than lane 0.
REQ-002 SHALL take parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL take parameter PC_WIDTH, default 32: PC width.
REQ-004 SHALL take parameter RF_DEPTH_BIT, default 5: register index width, giving 32 entries.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port lsu_rf_pipe_vld[lane], input, 1: the lane slot holds a retiring instruction.
REQ-008 SHALL have port lsu_rf_pc[lane], input, PC_WIDTH: PC of that instruction.
REQ-009 SHALL have port lsu_rf_rd[lane], input, RF_DEPTH_BIT: destination register.
REQ-010 SHALL have port lsu_rf_wen[lane], input, 1: register-file write request.
REQ-011 SHALL have port lsu_rf_wr_data[lane], input, DATA_WIDTH: writeback data.
REQ-012 SHALL have port idu_rf_rs1[lane] / idu_rf_rs2[lane], input, RF_DEPTH_BIT: read addresses.
REQ-013 SHALL have port rf_idu_rs1_data[lane] / rf_idu_rs2_data[lane], output, DATA_WIDTH: read data.
REQ-014 SHALL have port wbu_last_pc, output, PC_WIDTH: PC of the youngest instruction retired in the previous cycle.
REQ-015 SHALL have port wbu_retire_vld, output, 1: registered flag, high when at least one lane retired in the previous cycle.

Function
REQ-016 SHALL store 32 x DATA_WIDTH registers; a lane write is effective only if pipe_vld & wen & (rd != 0).
REQ-017 SHALL write effective lanes on the clock edge; write-to-array latency is 1 cycle.
REQ-018 SHALL, when both lanes write the same rd in one cycle, commit only the lane 1 data.
REQ-019 SHALL keep x0 at 0: reads of index 0 return 0 and writes to x0 are dropped.
REQ-020 SHALL make reads combinational, with same-cycle write bypass: an effective write to a read address is forwarded (lane 1 over lane 0), otherwise the array value is returned.
REQ-021 SHALL register wbu_last_pc with lane 1 PC if lane 1 pipe_vld, else lane 0 PC if lane 0 pipe_vld, else hold its value.
REQ-022 SHALL set wbu_retire_vld to (pipe_vld[0] | pipe_vld[1]) registered.
REQ-023 SHALL ignore wen, rd and data on any lane whose pipe_vld is 0.

Reset
REQ-024 SHALL, while rst is high, clear all 32 registers, wbu_last_pc and wbu_retire_vld (and wbu_retire_cnt when present) to 0 at the next edge.
REQ-025 SHALL let reset win over simultaneous writes; the writes in a reset cycle are lost.
REQ-026 SHALL forward no bypass data while rst is high; reads return 0.

Configuration
REQ-027 SHALL, with macro WBU_RETIRE_CNT_EN defined, provide output wbu_retire_cnt (64 bits), which increments each cycle by the number of lanes with pipe_vld (0, 1 or 2) and wraps modulo 2^64.
REQ-028 SHALL, without WBU_RETIRE_CNT_EN, omit the wbu_retire_cnt port and its counter entirely.

Structure
REQ-029 SHALL take SUPER_SCALAR_NUM, DATA_WIDTH, PC_WIDTH and RF_DEPTH_BIT from the shared define package used by the LSU and IDU, and define no local copies.
REQ-030 SHALL place the register array and its write logic in one sub-module, u_rf_2w4r, with 2 write ports and 4 read ports; forwarding, PC tracking and the counter stay in the top level.

Verification
REQ-031 SHALL cover: lane0 vld/wen, rd=5, data=0xDEADBEEF -> the next cycle a read of x5 returns 0xDEADBEEF, and the same-cycle read also returns it via bypass.
REQ-032 SHALL cover: both lanes write rd=7, lane0 0x11 and lane1 0x22 -> x7 = 0x22; the same-cycle read of x7 returns 0x22.
REQ-033 SHALL cover: write rd=0, data 0xFFFFFFFF -> reads of x0 return 0 in the same cycle and afterwards.
REQ-034 SHALL cover: lane0 pipe_vld=0 with wen=1, rd=3 -> x3 unchanged; wbu_retire_vld=0; wbu_last_pc holds.
REQ-035 SHALL cover: x9 = 0x55 then rst high for 1 cycle together with a write of x9 = 0x66 -> x9 = 0, wbu_last_pc = 0, wbu_retire_vld = 0.
REQ-036 SHALL cover, with WBU_RETIRE_CNT_EN: three cycles with vld patterns {11, 01, 00} and lane PCs 0x100/0x104, 0x108/- -> wbu_retire_cnt = 3 and wbu_last_pc = 0x108.
